bus_arbiter_2m: RTL



---
 rtl/bus_arbiter_2m_if.sv | 21 ++
 rtl/bus_arbiter_2m.sv | 112 +++++++++++
 2 files changed

// File: rtl/bus_arbiter_2m_if.sv
// rtl/bus_arbiter_2m_if.sv - request/grant bundle between bus masters, slave side and the arbiter
interface bus_arbiter_2m_if;
  logic m1_req;
  logic m2_req;
  logic trans_done;
  logic m1_grant;
  logic m2_grant;
  logic msel;
  logic bus_busy;
  logic timeout_err;

  modport master (
    output m1_req, m2_req, trans_done,
    input  m1_grant, m2_grant, msel, bus_busy, timeout_err
  );

  modport slave (
    input  m1_req, m2_req, trans_done,
    output m1_grant, m2_grant, msel, bus_busy, timeout_err
  );
endinterface

// File: rtl/bus_arbiter_2m.sv
// rtl/bus_arbiter_2m.sv - two-master bus arbiter with registered grants and a dead cycle between owners
// Optional grant timeout is enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter_2m #(
  parameter int PRIORITY_MODE  = 0,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic           clk,
  input  logic           rstn,
  bus_arbiter_2m_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_OWN_M1  = 2'd1,
    S_OWN_M2  = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  if (TIMEOUT_CYCLES >= (1 << CNT_WIDTH)) begin : g_bad_cfg
    $error("bus_arbiter_2m: CNT_WIDTH too small for TIMEOUT_CYCLES");
  end

  state_t r_state;
  logic   r_last_m2;
  logic   r_m1_grant;
  logic   r_m2_grant;
  logic   r_msel;
  logic   r_bus_busy;
  logic   r_timeout_err;

  logic   w_any_req;
  logic   w_pick_m2;
  logic   w_owner_req;
  logic   w_release;
  logic   w_timeout;

  assign w_any_req   = bus.m1_req | bus.m2_req;
  // On a tie, round-robin hands the bus to whoever was not served last.
  assign w_pick_m2   = bus.m2_req & (~bus.m1_req | ((PRIORITY_MODE == 0) & ~r_last_m2));
  assign w_owner_req = (r_state == S_OWN_M1) ? bus.m1_req : bus.m2_req;
  assign w_release   = bus.trans_done | ~w_owner_req;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [CNT_WIDTH-1:0] L_TIMEOUT = CNT_WIDTH'(TIMEOUT_CYCLES);

  logic [CNT_WIDTH-1:0] r_hold_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_inc;

  assign w_cnt_inc = (&r_hold_cnt) ? r_hold_cnt : r_hold_cnt + CNT_WIDTH'(1);
  // A normal release in the same cycle wins over the timeout.
  assign w_timeout = ~w_release & (w_cnt_inc == L_TIMEOUT);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_last_m2     <= 1'b1;
      r_m1_grant    <= 1'b0;
      r_m2_grant    <= 1'b0;
      r_msel        <= 1'b0;
      r_bus_busy    <= 1'b0;
      r_timeout_err <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      r_hold_cnt    <= '0;
`endif
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state    <= w_pick_m2 ? S_OWN_M2 : S_OWN_M1;
            r_m1_grant <= ~w_pick_m2;
            r_m2_grant <= w_pick_m2;
            r_msel     <= w_pick_m2;
            r_bus_busy <= 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
            r_hold_cnt <= '0;
`endif
          end
        end
        S_OWN_M1, S_OWN_M2: begin
          if (w_release || w_timeout) begin
            r_state       <= S_RELEASE;
            r_last_m2     <= (r_state == S_OWN_M2);
            r_m1_grant    <= 1'b0;
            r_m2_grant    <= 1'b0;
            r_bus_busy    <= 1'b0;
            r_timeout_err <= w_timeout;
          end
`ifdef BUS_ARB_TIMEOUT_EN
          else begin
            r_hold_cnt <= w_cnt_inc;
          end
`endif
        end
        // msel is left untouched here so the mux never moves under a live grant.
        S_RELEASE: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.m1_grant    = r_m1_grant;
  assign bus.m2_grant    = r_m2_grant;
  assign bus.msel        = r_msel;
  assign bus.bus_busy    = r_bus_busy;
  assign bus.timeout_err = r_timeout_err;

endmodule
